clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divide controller. Generates a divided clock level and a rising-edge tick from the system clock. Accepts divide-ratio updates through a valid/ready handshake and applies them only at a period boundary, so no runt or stretched phase occurs. Start and stop are glitch-free. Sits beside the fixed-ratio divider and replaces it wherever software or an upstream FSM must change the ratio on the fly.

Parameters:
- CNT_W, 8: width of the ratio and the phase counter.
- DEF_DIV, 4: ratio loaded at reset.
- MIN_DIV, 2: smallest legal ratio. Requests below it are rejected.

Ports:
- clk  in  1  system/reference clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run request. Level-sensitive.
- cfg_valid  in  1  ratio update request.
- cfg_div  in  CNT_W  requested ratio N.
- cfg_ready  out  1  controller can take an update.
- cfg_err  out  1  one-cycle pulse: an accepted request had N < MIN_DIV and was dropped.
- clk_out  out  1  divided clock level, registered.
- tick  out  1  one-cycle pulse coincident with each clk_out 0->1 transition.
- busy  out  1  state != OFF.
- cur_div  out  CNT_W  ratio currently in force.

Behaviour:
- Reset values:
  - State OFF, cnt = 0, cur_div = DEF_DIV, no pending ratio.
  - clk_out = 0, tick = 0, cfg_err = 0, busy = 0, cfg_ready = 1.
- Phase counter:
  - cnt runs 0..cur_div-1 and then wraps to 0.
  - clk_out = (cnt >= cur_div/2), using integer divide, and comes from a flop.
  - Low phase is floor(N/2) cycles; high phase is ceil(N/2) cycles. Example N=5: 2 low, 3 high.
  - tick = 1 in the cycle where cnt == cur_div/2.
- States:
  - OFF: cnt held at 0, clk_out 0. When en = 1, go to RUN; counting starts on the next edge.
  - RUN: counts. When en = 0, go to DRAIN.
  - DRAIN: keeps counting until the cycle where cnt == cur_div-1, then goes to OFF with cnt = 0. The last period always completes. If en returns to 1 during DRAIN, go back to RUN with no disturbance to cnt.
- Handshake:
  - A transfer happens when cfg_valid && cfg_ready. cfg_ready = !pending.
  - cfg_div < MIN_DIV: the transfer completes, cfg_err pulses the next cycle, nothing is stored.
  - Legal value in OFF: cur_div is updated on the next edge; pending stays 0.
  - Legal value in RUN or DRAIN: stored in pend_div with pending = 1.
- Update application:
  - pend_div is copied to cur_div on the edge where cnt == cur_div-1 (the wrap edge). pending clears on that same edge.
  - The next period uses the new ratio from cnt = 0.
- Simultaneous events:
  - Wrap and a new transfer in the same cycle: cfg_ready is 0 while pending, so the new transfer waits. With no pending value, a value accepted on the wrap edge applies at the following wrap, not immediately.
  - DRAIN->OFF on a wrap with a pending value: pending is applied as it enters OFF.
- Rates: ratio CNT_W'1s is legal (255 for CNT_W = 8). Throughput is one update per period.
- rst mid-operation: everything returns to its reset value on that edge and any pending value is discarded.

Optional Feature:
- Macro CLK_DIV_CTRL_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt (16 bits), which increments on every wrap edge in RUN or DRAIN and wraps at 0xFFFF -> 0.
  - Cleared by rst. Held, not cleared, in OFF.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package clk_div_ctrl_pkg holds:
  - the state enum typedef (OFF, RUN, DRAIN);
  - the default CNT_W and DEF_DIV constants.
- One natural sub-module, clk_div_phase_cnt:
  - the counter, the clk_out/tick decode, and the wrap flag;
  - fed cur_div and a run enable.
- The FSM and handshake stay in the top level.

Test Plan:
- Reset, en = 1, DEF_DIV = 4:
  - clk_out pattern 0,0,1,1 repeating;
  - tick when cnt == 2;
  - busy = 1 one cycle after en.
- Running N=4, cfg_div = 6 accepted mid-period:
  - cfg_ready drops;
  - the current period finishes at 4 cycles, then periods are 6 cycles (3 low, 3 high);
  - cur_div changes exactly on the wrap edge.
- cfg_div = 5: 2 low, 3 high. cfg_div = 1: cfg_err pulses once, cur_div unchanged, cfg_ready stays 1.
- en deasserted at cnt == 1 with N = 4:
  - counting continues to cnt == 3, then OFF with clk_out = 0, busy = 0.
  - Repeat with en reasserted at cnt == 2: no gap in the clk_out pattern.
- Pending value present when a DRAIN completes: cur_div takes the pending value on entry to OFF; the next en run uses it.
- rst pulsed while pending with N = 8 at cnt == 5:
  - all outputs return to reset values, cur_div = 4, pending cleared.
  - With CLK_DIV_CTRL_PERIOD_CNT_EN defined, period_cnt = 0, and it reads 3 after three subsequent periods.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the programmable clock-divide controller.
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN (see clk_div_ctrl).
package clk_div_ctrl_pkg;

   localparam int CNT_W_DEF   = 8;
   localparam int DEF_DIV_DEF = 4;
   localparam int MIN_DIV_DEF = 2;
   localparam int PCNT_W      = 16;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter with registered clk_out/tick decode and a wrap flag.
// Outputs are computed from the next count so they line up with the count.
module clk_div_phase_cnt
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_clk_out,
   output logic             o_tick,
   output logic             o_wrap
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_half;
   logic             w_wrap;
   logic             r_clk_out;
   logic             r_tick;

   assign w_half = i_div >> 1;
   assign w_wrap = i_run && (r_cnt == (i_div - CNT_W'(1)));

   // Count is 0 on wrap, so a ratio change at the wrap cannot glitch clk_out.
   always_comb begin
      w_cnt_nxt = '0;
      if (i_run && !w_wrap) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_clk_out <= (w_cnt_nxt >= w_half);
         r_tick    <= (w_cnt_nxt == w_half);
      end
   end

   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;
   assign o_wrap    = w_wrap;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: run FSM, ratio handshake, phase counter.
// Define CLK_DIV_CTRL_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = DEF_DIV_DEF,
   parameter int MIN_DIV = MIN_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   output logic [PCNT_W-1:0] period_cnt,
`endif
   output logic [CNT_W-1:0] cur_div
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_run;
   logic             w_wrap;
   logic             w_xfer;
   logic             w_bad;
   logic [CNT_W-1:0] r_cur_div;
   logic [CNT_W-1:0] r_pend_div;
   logic             r_pending;
   logic             r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         OFF: begin
            if (en) w_state_nxt = RUN;
         end
         RUN: begin
            if (!en) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (en) begin
               w_state_nxt = RUN;
            end else if (w_wrap) begin
               w_state_nxt = OFF;
            end
         end
         default: w_state_nxt = OFF;
      endcase
   end

   always_comb begin
      w_run = (r_state != OFF);
      busy  = w_run;
   end

   assign cfg_ready = !r_pending;
   assign w_xfer    = cfg_valid && cfg_ready;
   assign w_bad     = (cfg_div < CNT_W'(MIN_DIV));

   // A pending ratio blocks new transfers, so apply and accept never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur_div  <= CNT_W'(DEF_DIV);
         r_pend_div <= '0;
         r_pending  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_xfer && w_bad;
         if (w_wrap && r_pending) begin
            r_cur_div <= r_pend_div;
            r_pending <= 1'b0;
         end else if (w_xfer && !w_bad) begin
            if (r_state == OFF) begin
               r_cur_div <= cfg_div;
            end else begin
               r_pend_div <= cfg_div;
               r_pending  <= 1'b1;
            end
         end
      end
   end

   assign cfg_err = r_err;
   assign cur_div = r_cur_div;

   clk_div_phase_cnt #(
      .CNT_W(CNT_W)
   ) u_phase (
      .clk      (clk),
      .rst      (rst),
      .i_run    (w_run),
      .i_div    (r_cur_div),
      .o_clk_out(clk_out),
      .o_tick   (tick),
      .o_wrap   (w_wrap)
   );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [PCNT_W-1:0] r_period_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_period_cnt <= '0;
      end else if (w_wrap) begin
         r_period_cnt <= r_period_cnt + PCNT_W'(1);
      end
   end

   assign period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_clk_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfg_valid;
   logic [7:0]  cfg_div;
   logic        cfg_ready;
   logic        cfg_err;
   logic        clk_out;
   logic        tick;
   logic        busy;
   logic [7:0]  cur_div;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       clk_out;
      logic       tick;
      logic       busy;
      logic       rdy;
      logic       err;
      logic [7:0] div;
      logic       chk_pc;
      int         pc;
      string      nm;
   } exp_t;

   exp_t sb[$];
   logic g_chk_pc = 1'b0;
   int   g_pc     = 0;

   clk_div_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      .period_cnt(period_cnt),
`endif
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   // c = expected phase count after the edge, d = ratio in force after it.
   task automatic step(input int c, input logic b, input logic r,
                       input logic e, input int d, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      x.clk_out = (c >= d / 2);
      x.tick    = (c == d / 2);
      x.busy    = b;
      x.rdy     = r;
      x.err     = e;
      x.div     = 8'(d);
      x.chk_pc  = g_chk_pc;
      x.pc      = g_pc;
      x.nm      = nm;
      g_chk_pc  = 1'b0;
      sb.push_back(x);
   endtask

   task automatic periods(input int d, input int n, input string nm);
      for (int p = 0; p < n; p++) begin
         for (int c = 1; c < d; c++) step(c, 1, 1, 0, d, nm);
         step(0, 1, 1, 0, d, nm);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if ({clk_out, tick, busy, cfg_ready, cfg_err, cur_div} !==
                {x.clk_out, x.tick, x.busy, x.rdy, x.err, x.div}) begin
               failures++;
               $display("FAIL %s: got clk=%0b tick=%0b busy=%0b rdy=%0b err=%0b div=%0d want clk=%0b tick=%0b busy=%0b rdy=%0b err=%0b div=%0d",
                        x.nm, clk_out, tick, busy, cfg_ready, cfg_err, cur_div,
                        x.clk_out, x.tick, x.busy, x.rdy, x.err, x.div);
            end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
            if (x.chk_pc) begin
               checks++;
               if (period_cnt !== 16'(x.pc)) begin
                  failures++;
                  $display("FAIL %s period_cnt: got %0d want %0d",
                           x.nm, period_cnt, x.pc);
               end
            end
`endif
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
      step(0, 0, 1, 0, 4, "reset");
      step(0, 0, 1, 0, 4, "reset_hold");
      rst = 1'b0;
      step(0, 0, 1, 0, 4, "off_idle");

      // Default ratio 4: busy one cycle after en, then 0,0,1,1.
      en = 1'b1;
      step(0, 1, 1, 0, 4, "busy_on");
      periods(4, 2, "div4");

      // Ratio 6 accepted mid-period, applied on the wrap.
      cfg_valid = 1'b1; cfg_div = 8'd6;
      step(1, 1, 0, 0, 4, "acc6");
      cfg_valid = 1'b0;
      step(2, 1, 0, 0, 4, "pend6");
      step(3, 1, 0, 0, 4, "pend6");
      step(0, 1, 1, 0, 6, "wrap6");
      periods(6, 2, "div6");

      // Ratio 5: 2 low, 3 high.
      cfg_valid = 1'b1; cfg_div = 8'd5;
      step(1, 1, 0, 0, 6, "acc5");
      cfg_valid = 1'b0;
      for (int c = 2; c < 6; c++) step(c, 1, 0, 0, 6, "pend5");
      step(0, 1, 1, 0, 5, "wrap5");
      periods(5, 2, "div5");

      // Illegal ratio 1: error pulse, nothing stored.
      cfg_valid = 1'b1; cfg_div = 8'd1;
      step(1, 1, 1, 1, 5, "err1");
      cfg_valid = 1'b0;
      step(2, 1, 1, 0, 5, "err_clear");
      step(3, 1, 1, 0, 5, "err_div5");
      step(4, 1, 1, 0, 5, "err_div5");
      step(0, 1, 1, 0, 5, "err_div5");

      // Back to ratio 4.
      cfg_valid = 1'b1; cfg_div = 8'd4;
      step(1, 1, 0, 0, 5, "acc4");
      cfg_valid = 1'b0;
      for (int c = 2; c < 5; c++) step(c, 1, 0, 0, 5, "pend4");
      step(0, 1, 1, 0, 4, "wrap4");

      // Stop at cnt 1: drain finishes the period.
      step(1, 1, 1, 0, 4, "pre_stop");
      en = 1'b0;
      step(2, 1, 1, 0, 4, "drain");
      step(3, 1, 1, 0, 4, "drain");
      step(0, 0, 1, 0, 4, "off_after_drain");
      step(0, 0, 1, 0, 4, "off_hold");

      // Stop then restart during drain: no gap.
      en = 1'b1;
      step(0, 1, 1, 0, 4, "restart");
      step(1, 1, 1, 0, 4, "restart");
      en = 1'b0;
      step(2, 1, 1, 0, 4, "drain_r");
      en = 1'b1;
      step(3, 1, 1, 0, 4, "rerun");
      step(0, 1, 1, 0, 4, "rerun");
      periods(4, 1, "rerun4");

      // Pending ratio applied as the drain enters OFF.
      cfg_valid = 1'b1; cfg_div = 8'd3; en = 1'b0;
      step(1, 1, 0, 0, 4, "acc3_drain");
      cfg_valid = 1'b0;
      step(2, 1, 0, 0, 4, "drain3");
      step(3, 1, 0, 0, 4, "drain3");
      step(0, 0, 1, 0, 3, "off_div3");
      step(0, 0, 1, 0, 3, "off_div3_hold");
      en = 1'b1;
      step(0, 1, 1, 0, 3, "run3");
      periods(3, 2, "div3");

      // Ratio 8, then reset at cnt 5 with ratio 7 pending.
      cfg_valid = 1'b1; cfg_div = 8'd8;
      step(1, 1, 0, 0, 3, "acc8");
      cfg_valid = 1'b0;
      step(2, 1, 0, 0, 3, "pend8");
      step(0, 1, 1, 0, 8, "wrap8");
      cfg_valid = 1'b1; cfg_div = 8'd7;
      step(1, 1, 0, 0, 8, "acc7");
      cfg_valid = 1'b0;
      for (int c = 2; c < 6; c++) step(c, 1, 0, 0, 8, "pend7");
      rst = 1'b1; en = 1'b0;
      g_chk_pc = 1'b1; g_pc = 0;
      step(0, 0, 1, 0, 4, "rst_mid");
      rst = 1'b0;
      step(0, 0, 1, 0, 4, "rst_idle");
      en = 1'b1;
      step(0, 1, 1, 0, 4, "post_rst_run");
      for (int p = 1; p <= 3; p++) begin
         for (int c = 1; c < 4; c++) step(c, 1, 1, 0, 4, "post_rst");
         g_chk_pc = 1'b1; g_pc = p;
         step(0, 1, 1, 0, 4, "post_rst_wrap");
      end
      en = 1'b0;

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_queue: got %0d entries left want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
